mux_rd_arbiter: RTL
===================

Name: mux_rd_arbiter

Overview:
- Round-robin arbiter that shares one read port of the mux4096to1_n read datapath between NREQ requesters.
- Picks one requester per cycle and drives its address onto the mux select.
- Registers the mux output and returns it with a valid flag and the requester id.
- Sits between the core-side read clients (fetch, operand read, debug) and the 4096-entry mux storage read path.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 12, select width; matches the mux address width.
- DATA_W, 4, data width n of the mux.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  NREQ  per-requester read request.
- addr_i  input  NREQ x ADDR_W  per-requester read address (unpacked array [0:NREQ-1]).
- hold_i  input  1  blocks all new grants this cycle (e.g. storage being written).
- gnt_o  output  NREQ  one-hot grant, combinational, at most one bit set.
- mux_sel_o  output  ADDR_W  select to the mux; address of the current winner.
- mux_data_i  input  DATA_W  data_o returned by the mux.
- rvalid_o  output  1  read data valid.
- rid_o  output  $clog2(NREQ)  index of the requester owning rdata_o.
- rdata_o  output  DATA_W  registered read data.

Behaviour:
- Reset (async, rst_i=1): rr_ptr=0, rvalid_o=0, rid_o=0, rdata_o=0, pipe registers cleared. gnt_o=0 and mux_sel_o=0 while rst_i=1.
- Handshake: a requester holds req_i and a stable addr_i until it sees its gnt_o bit high at a clock edge. The grant is a single-cycle acceptance. The requester may keep req_i high for back-to-back reads.
- Arbitration (cycle t): if hold_i=0 and any req_i is set, the winner is the first set req_i scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - gnt_o[winner]=1.
  - mux_sel_o=addr_i[winner]; otherwise mux_sel_o holds its last driven value (no toggling).
- Pointer: at the edge ending a granting cycle, rr_ptr <= (winner+1) mod NREQ. It is unchanged when nothing is granted. Wrap from NREQ-1 to 0 is required.
- Return path (no pipe): at the edge ending cycle t, rdata_o <= mux_data_i, rid_o <= winner, rvalid_o <= 1. Read latency is 1 cycle and throughput is 1 read per cycle.
- Idle cycle (no request, or hold_i=1): rvalid_o <= 0. rdata_o and rid_o keep their last values.
- hold_i and req_i together: hold wins. No grant and no pointer advance. A request dropped and re-raised is treated as new.
- Single requester: it is granted every cycle regardless of rr_ptr.
- Reset mid-operation: an in-flight read is discarded; rvalid_o drops asynchronously.
- Fairness: with all NREQ requesting continuously, each is granted exactly once per NREQ cycles.

Optional Feature:
- Macro: MUX_RD_PIPE_EN.
- Defined:
  - mux_sel_o is driven from a register loaded with the winner's address at the grant edge, so the mux sees it in t+1.
  - The winner id is also pipelined.
  - mux_data_i is captured at the end of t+1, so rvalid_o is high in t+2. Latency 2, throughput still 1 per cycle.
  - gnt_o timing is unchanged.
- Undefined: latency 1 as above, and mux_sel_o is combinational from the arbiter.

Decomposition:
- Package mux_arb_pkg holds:
  - constants NREQ_DEF=4, ADDR_W_DEF=12, DATA_W_DEF=4;
  - typedef addr_t logic[ADDR_W_DEF-1:0];
  - typedef req_id_t logic[$clog2(NREQ_DEF)-1:0].
- One sub-module, rr_picker: combinational rotate-priority find-first.
  - Inputs: req vector, pointer.
  - Outputs: found flag, winner index, one-hot grant.
- The top holds rr_ptr, the return registers and the optional pipe.

Test Plan:
- Reset: rst_i pulsed mid-cycle with rvalid_o=1 -> rvalid_o, rdata_o, rid_o drop to 0 immediately; the first grant after release goes to requester 0.
- Single read: req_i=4'b0100, addr_i[2]=12'h3A5, mux model returns 4'h9 -> gnt_o=0100 in the same cycle, mux_sel_o=12'h3A5; next cycle rvalid_o=1, rid_o=2, rdata_o=4'h9. With MUX_RD_PIPE_EN, the valid appears one cycle later.
- Round-robin: req_i=4'b1111 held for 8 cycles from rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3 with rvalid_o high for 8 consecutive cycles.
- Wrap/skip: rr_ptr=3, req_i=4'b0011 -> grants 0 then 1 then 0; requester 3 is never granted.
- Hold: req_i=4'b0010 with hold_i=1 for 3 cycles -> gnt_o=0, rvalid_o=0, rr_ptr unchanged; the grant to 1 occurs the cycle hold_i falls.
- Back-to-back addresses: requester 1 reads 12'h000 then 12'hFFF on consecutive grants -> rdata_o matches the model's data for each address in order with rid_o=1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared defaults and types for the mux read-port arbiter.
package mux_arb_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 4;

    typedef logic [ADDR_W_DEF-1:0]        addr_t;
    typedef logic [$clog2(NREQ_DEF)-1:0]  req_id_t;

endpackage

// File: rtl/mux_rd_arbiter_rr_picker.sv
// Rotating-priority find-first: returns the first set request at or after ptr,
// wrapping modulo NREQ, as an index and as a one-hot vector.
module rr_picker #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  idx,
    output logic [NREQ-1:0] gnt
);

    logic [IDW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop; without it a
        // path that assigns nothing would infer a latch.
        found = 1'b0;
        idx   = '0;
        gnt   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_rd_arbiter.sv
// Round-robin arbiter sharing one mux read port among NREQ requesters.
// Define MUX_RD_PIPE_EN to register the mux select (read latency 2 instead of 1).
module mux_rd_arbiter
    import mux_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [ADDR_W-1:0] addr_i [0:NREQ-1],
    input  logic              hold_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [ADDR_W-1:0] mux_sel_o,
    input  logic [DATA_W-1:0] mux_data_i,
    output logic              rvalid_o,
    output logic [IDW-1:0]    rid_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    win;
    logic              found;
    logic              grant;
    logic [NREQ-1:0]   pick_gnt;
    logic [ADDR_W-1:0] sel_q;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (req_i),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (win),
        .gnt   (pick_gnt)
    );

    // Hold and reset both suppress the grant, so the pointer stays put too.
    assign grant = found & ~hold_i & ~rst_i;
    assign gnt_o = grant ? pick_gnt : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst_i) begin
            rr_ptr <= '0;
            sel_q  <= '0;
        end else if (grant) begin
            rr_ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            sel_q  <= addr_i[win];
        end
    end

`ifdef MUX_RD_PIPE_EN
    logic           pipe_valid;
    logic [IDW-1:0] pipe_id;

    // The mux sees the registered address one cycle after the grant.
    assign mux_sel_o = sel_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid <= 1'b0;
            pipe_id    <= '0;
            rvalid_o   <= 1'b0;
            rid_o      <= '0;
            rdata_o    <= '0;
        end else begin
            pipe_valid <= grant;
            if (grant) begin
                pipe_id <= win;
            end
            rvalid_o <= pipe_valid;
            if (pipe_valid) begin
                rdata_o <= mux_data_i;
                rid_o   <= pipe_id;
            end
        end
    end
`else
    // Idle cycles replay the last select so the mux input does not toggle.
    assign mux_sel_o = grant ? addr_i[win] : sel_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rid_o    <= '0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= grant;
            if (grant) begin
                rdata_o <= mux_data_i;
                rid_o   <= win;
            end
        end
    end
`endif

endmodule
